// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch-side lookup and EX-side training bus for the branch predictor
interface branch_predictor_if #(
   parameter int WORD = 32
);
   logic [WORD-1:0] PC;
   logic            Pre_Branch;
   logic [WORD-1:0] Pre_PC;
   logic            EX_update;
   logic [WORD-1:0] EX_inst_PC;
   logic            EX_taken;
   logic [WORD-1:0] EX_target;
   logic            EX_Branch;
   logic            update_stall;
   logic [31:0]     Mispredict_cnt;

   modport master (
      output PC, EX_update, EX_inst_PC, EX_taken, EX_target, EX_Branch, update_stall,
      input  Pre_Branch, Pre_PC, Mispredict_cnt
   );

   modport slave (
      input  PC, EX_update, EX_inst_PC, EX_taken, EX_target, EX_Branch, update_stall,
      output Pre_Branch, Pre_PC, Mispredict_cnt
   );
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters and a mispredict counter
module branch_predictor #(
   parameter int ENTRIES = 64,
   parameter int WORD    = 32
) (
   input logic               clk,
   input logic               rst,
   branch_predictor_if.slave bus
);
   localparam int IDX  = $clog2(ENTRIES);
   localparam int TAGW = WORD - IDX - 2;

   logic            valid   [ENTRIES];
   logic [1:0]      ctr     [ENTRIES];
   logic [TAGW-1:0] tag_mem [ENTRIES];
   logic [WORD-1:0] tgt_mem [ENTRIES];

   logic [IDX-1:0]  rd_idx;
   logic [TAGW-1:0] rd_tag;
   logic            rd_hit;

   logic [IDX-1:0]  wr_idx;
   logic [TAGW-1:0] wr_tag;
   logic            wr_hit;
   logic            we;

   logic [31:0]     mis_cnt;

   // Lookup reads the pre-write contents; a same-cycle write lands after the edge.
   assign rd_idx         = bus.PC[IDX+1:2];
   assign rd_tag         = bus.PC[WORD-1:IDX+2];
   assign rd_hit         = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
   assign bus.Pre_Branch = rd_hit & ctr[rd_idx][1];
   assign bus.Pre_PC     = bus.Pre_Branch ? tgt_mem[rd_idx] : bus.PC + WORD'(4);

   assign wr_idx = bus.EX_inst_PC[IDX+1:2];
   assign wr_tag = bus.EX_inst_PC[WORD-1:IDX+2];
   assign wr_hit = valid[wr_idx] && (tag_mem[wr_idx] == wr_tag);
   assign we     = bus.EX_update & ~bus.update_stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid[i] <= 1'b0;
            ctr[i]   <= 2'b01;
         end
      end else if (we) begin
         if (wr_hit) begin
            if (bus.EX_taken && ctr[wr_idx] != 2'b11)
               ctr[wr_idx] <= ctr[wr_idx] + 2'b01;
            else if (!bus.EX_taken && ctr[wr_idx] != 2'b00)
               ctr[wr_idx] <= ctr[wr_idx] - 2'b01;
         end else if (bus.EX_taken) begin
            valid[wr_idx] <= 1'b1;
            ctr[wr_idx]   <= 2'b10;
         end
      end
   end

   // Tag/target carry no reset; they are only meaningful behind valid.
   always_ff @(posedge clk) begin
      if (we && bus.EX_taken) begin
         tag_mem[wr_idx] <= wr_tag;
         tgt_mem[wr_idx] <= bus.EX_target;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         mis_cnt <= 32'd0;
      else if (bus.EX_Branch && !bus.update_stall && mis_cnt != 32'hFFFF_FFFF)
         mis_cnt <= mis_cnt + 32'd1;
   end

   assign bus.Mispredict_cnt = mis_cnt;
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - randomized and directed checks of branch_predictor against a table model
module tb_branch_predictor;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   branch_predictor_if #(.WORD(32)) bus ();
   branch_predictor #(.ENTRIES(64), .WORD(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   bit          m_valid [64];
   logic [31:0] m_tag   [64];
   logic [31:0] m_tgt   [64];
   int          m_ctr   [64];
   longint      m_cnt;

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc / 4) % 64);
   endfunction

   function automatic logic [31:0] tag_of(input logic [31:0] pc);
      return pc / 256;
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      return m_valid[idx_of(pc)] && m_tag[idx_of(pc)] == tag_of(pc);
   endfunction

   function automatic logic m_pred(input logic [31:0] pc);
      return m_hit(pc) && m_ctr[idx_of(pc)] >= 2;
   endfunction

   function automatic logic [31:0] m_next(input logic [31:0] pc);
      return m_pred(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 64; i++) begin
         m_valid[i] = 1'b0;
         m_ctr[i]   = 1;
      end
      m_cnt = 0;
   endtask

   task automatic m_train(input bit upd, input logic [31:0] ex_pc, input bit taken,
                          input logic [31:0] tgt, input bit exb, input bit stall);
      int i;
      i = idx_of(ex_pc);
      if (upd && !stall) begin
         if (m_hit(ex_pc)) begin
            if (taken) begin
               m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
               m_tgt[i] = tgt;
            end else begin
               m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
         end else if (taken) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = tag_of(ex_pc);
            m_tgt[i]   = tgt;
            m_ctr[i]   = 2;
         end
      end
      if (exb && !stall && m_cnt < 64'hFFFF_FFFF) m_cnt++;
   endtask

   task automatic drive(input logic [31:0] pc, input bit upd, input logic [31:0] ex_pc,
                        input bit taken, input logic [31:0] tgt, input bit exb, input bit stall);
      bus.PC           = pc;
      bus.EX_update    = upd;
      bus.EX_inst_PC   = ex_pc;
      bus.EX_taken     = taken;
      bus.EX_target    = tgt;
      bus.EX_Branch    = exb;
      bus.update_stall = stall;
   endtask

   // One clock: drive in the low phase, compare against the model, then apply the edge to the model.
   task automatic cycle(input string tag, input logic [31:0] pc, input bit upd,
                        input logic [31:0] ex_pc, input bit taken, input logic [31:0] tgt,
                        input bit exb, input bit stall);
      drive(pc, upd, ex_pc, taken, tgt, exb, stall);
      #1;
      chk({tag, ".pred"}, 32'(bus.Pre_Branch), 32'(m_pred(pc)));
      chk({tag, ".ppc"}, bus.Pre_PC, m_next(pc));
      chk({tag, ".cnt"}, bus.Mispredict_cnt, m_cnt[31:0]);
      @(posedge clk);
      m_train(upd, ex_pc, taken, tgt, exb, stall);
      @(negedge clk);
   endtask

   task automatic look(input logic [31:0] pc);
      drive(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      #1;
   endtask

   task automatic upd(input string tag, input logic [31:0] ex_pc, input bit taken, input logic [31:0] tgt);
      cycle(tag, ex_pc, 1'b1, ex_pc, taken, tgt, 1'b0, 1'b0);
   endtask

   function automatic logic [31:0] rand_pc();
      return 32'h1C00_0000 + ({28'd0, 4'($urandom_range(0, 15))} << 2)
                           + ({31'd0, 1'($urandom_range(0, 1))} << 8);
   endfunction

   task automatic random_phase(input int n);
      logic [31:0] pc, ex_pc;
      for (int k = 0; k < n; k++) begin
         pc    = rand_pc();
         ex_pc = ($urandom_range(0, 3) == 0) ? pc : rand_pc();
         cycle("rnd", pc, 1'($urandom_range(0, 1)), ex_pc, 1'($urandom_range(0, 2) != 0),
               32'h1C10_0000 + ($urandom & 32'h0000_FFFC), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 4) == 0));
      end
   endtask

   initial begin
      m_reset();
      drive(32'h1C00_0000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      #12;
      chk("in_reset.pred", 32'(bus.Pre_Branch), 32'h0);
      chk("in_reset.ppc", bus.Pre_PC, 32'h1C00_0004);
      @(negedge clk);
      rst = 1'b0;

      look(32'h1C00_0000);
      chk("reset.pred", 32'(bus.Pre_Branch), 32'h0);
      chk("reset.ppc", bus.Pre_PC, 32'h1C00_0004);
      chk("reset.cnt", bus.Mispredict_cnt, 32'h0);

      upd("alloc", 32'h1C00_0010, 1'b1, 32'h1C00_0100);
      look(32'h1C00_0010);
      chk("alloc.pred", 32'(bus.Pre_Branch), 32'h1);
      chk("alloc.ppc", bus.Pre_PC, 32'h1C00_0100);

      upd("hyst_nt1", 32'h1C00_0010, 1'b0, 32'h0);
      upd("hyst_nt2", 32'h1C00_0010, 1'b0, 32'h0);
      look(32'h1C00_0010);
      chk("hyst_01.pred", 32'(bus.Pre_Branch), 32'h0);
      upd("hyst_nt3", 32'h1C00_0010, 1'b0, 32'h0);
      upd("hyst_t1", 32'h1C00_0010, 1'b1, 32'h1C00_0100);
      look(32'h1C00_0010);
      chk("hyst_sat0.pred", 32'(bus.Pre_Branch), 32'h0);
      upd("hyst_t2", 32'h1C00_0010, 1'b1, 32'h1C00_0100);
      look(32'h1C00_0010);
      chk("hyst_10.pred", 32'(bus.Pre_Branch), 32'h1);
      upd("hyst_t3", 32'h1C00_0010, 1'b1, 32'h1C00_0100);
      upd("hyst_t4", 32'h1C00_0010, 1'b1, 32'h1C00_0100);
      upd("hyst_nt4", 32'h1C00_0010, 1'b0, 32'h0);
      look(32'h1C00_0010);
      chk("hyst_sat3.pred", 32'(bus.Pre_Branch), 32'h1);

      look(32'h1C00_0110);
      chk("alias.pred", 32'(bus.Pre_Branch), 32'h0);
      chk("alias.ppc", bus.Pre_PC, 32'h1C00_0114);
      upd("alias_alloc", 32'h1C00_0110, 1'b1, 32'h1C00_0200);
      look(32'h1C00_0010);
      chk("alias_evict.pred", 32'(bus.Pre_Branch), 32'h0);
      look(32'h1C00_0110);
      chk("alias_new.ppc", bus.Pre_PC, 32'h1C00_0200);
      upd("nt_miss", 32'h1C00_0020, 1'b0, 32'h1C00_0300);
      look(32'h1C00_0020);
      chk("nt_miss.pred", 32'(bus.Pre_Branch), 32'h0);

      for (int k = 0; k < 3; k++)
         cycle("stall", 32'h1C00_0030, 1'b1, 32'h1C00_0030, 1'b1, 32'h1C00_0400, 1'b1, 1'b1);
      look(32'h1C00_0030);
      chk("stall.pred", 32'(bus.Pre_Branch), 32'h0);
      chk("stall.cnt", bus.Mispredict_cnt, 32'h0);
      cycle("unstall", 32'h1C00_0030, 1'b1, 32'h1C00_0030, 1'b1, 32'h1C00_0400, 1'b1, 1'b0);
      look(32'h1C00_0030);
      chk("unstall.pred", 32'(bus.Pre_Branch), 32'h1);
      chk("unstall.cnt", bus.Mispredict_cnt, 32'h1);

      random_phase(400);

      upd("pre_rst", 32'h1C00_0030, 1'b1, 32'h1C00_0400);
      cycle("pre_rst_mis", 32'h1C00_0030, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      drive(32'h1C00_0030, 1'b1, 32'h1C00_0010, 1'b1, 32'h1C00_0500, 1'b1, 1'b0);
      #1;
      chk("mid_rst_before.pred", 32'(bus.Pre_Branch), 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst.pred", 32'(bus.Pre_Branch), 32'h0);
      chk("mid_rst.ppc", bus.Pre_PC, 32'h1C00_0034);
      chk("mid_rst.cnt", bus.Mispredict_cnt, 32'h0);
      m_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      look(32'h1C00_0010);
      chk("post_rst.pred", 32'(bus.Pre_Branch), 32'h0);
      chk("post_rst.ppc", bus.Pre_PC, 32'h1C00_0014);

      random_phase(200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
